dm_bus_master: RTL and testbench
================================

# dm_bus_master

Data-memory bus master directly downstream of the MEM stage. Consumes the MEM stage's combinational data-memory request (address, store data, byte write-enables, read/write strobes) and converts it into a multi-cycle valid/ready transaction on the data bus. It freezes the pipeline with `stall_o` until the access completes, then returns the full read word to the MEM stage's `data_i` for lane extraction and sign extension.

## Interface
- `ADDR_BITS`, 32, address width
- `DATA_BITS`, 32, data width
- `WEB_BITS`, 4, byte write-enable width (active-low, as produced by MEM)
- `TIMEOUT_CYCLES`, 255, watchdog limit; used only with `DM_BUS_TIMEOUT_EN`
- `clk`  in  1  single clock
- `rst`  in  1  reset, asynchronous, active-low
- `dm_addr_i`  in  ADDR_BITS  byte address from MEM
- `dm_sw_i`  in  DATA_BITS  lane-aligned store data
- `dm_web_i`  in  WEB_BITS  active-low byte write enables
- `dm_rd_i`, `dm_wr_i`  in  1  load / store request
- `hold_i`  in  1  pipeline frozen by another source
- `data_o`  out  DATA_BITS  read word to MEM `data_i`
- `stall_o`  out  1  freeze IF..MEM, deassert `memwb_en`
- `bus_err_o`  out  1  access completed with error
- `req_valid_o`  out  1; `req_ready_i`  in  1
- `req_addr_o`  out  ADDR_BITS  word-aligned address
- `req_write_o`  out  1; `req_wstrb_o`  out  WEB_BITS  active-high strobes
- `req_wdata_o`  out  DATA_BITS
- `rsp_valid_i`  in  1; `rsp_ready_o`  out  1
- `rsp_rdata_i`  in  DATA_BITS; `rsp_err_i`  in  1

## Operation
- FSM states: IDLE, REQ, RSP, DONE.
- IDLE: if `dm_rd_i|dm_wr_i`, then `stall_o`=1 combinationally the same cycle and next state is REQ. Otherwise stay in IDLE with `stall_o`=0.
- REQ: `req_valid_o`=1 and `stall_o`=1. Request fields are driven from the inputs, which are held stable by the stall.
  - `req_addr_o` = {addr[ADDR_BITS-1:2], 2'b00}.
  - `req_write_o` = `dm_wr_i`.
  - `req_wstrb_o` = `dm_wr_i` ? ~`dm_web_i` : 0.
  - `req_wdata_o` = `dm_sw_i`.
  - On `req_valid_o & req_ready_i`, go to RSP.
- RSP: `rsp_ready_o`=1 and `stall_o`=1. On `rsp_valid_i`:
  - loads register `rsp_rdata_i` into `data_o`; stores leave `data_o` unchanged;
  - register `rsp_err_i` into the error flag;
  - go to DONE.
- DONE: `stall_o`=0 so the pipeline latches MEM/WB. `bus_err_o` reflects the registered error flag.
  - If `hold_i`=1, stay in DONE. This prevents re-issuing the same access while the pipeline is still frozen.
  - Otherwise go to IDLE. `bus_err_o` is 0 outside DONE.
- `dm_rd_i` and `dm_wr_i` both high is illegal from MEM; write takes precedence.
- `rsp_valid_i` outside RSP is ignored. `req_ready_i` outside REQ is ignored.
- Request outputs are 0 whenever `req_valid_o`=0.

## Timing
- Reset (`rst`=0, async): state IDLE; `data_o`=0; `stall_o`, `bus_err_o`, `req_valid_o`, `rsp_ready_o`, `req_write_o`=0; `req_addr_o`, `req_wstrb_o`, `req_wdata_o`=0.
- Reset mid-transaction aborts to IDLE immediately with no completion. The bus is reset in the same domain.
- Minimum access, with `req_ready_i` and `rsp_valid_i` both tied high:
  - cycle 0: IDLE, access detected;
  - cycle 1: REQ handshake;
  - cycle 2: RSP capture;
  - cycle 3: DONE.
  - `stall_o` is high for cycles 0–2, i.e. 3 stall cycles.
- `data_o` is valid from the DONE cycle and holds until the next load capture.
- A back-to-back access in the next instruction is detected in the cycle after DONE. There is no bubble beyond the FSM.

## Configuration
- `DM_BUS_TIMEOUT_EN` defined:
  - a counter runs in REQ and RSP and clears on entry to REQ;
  - when it reaches `TIMEOUT_CYCLES` with no handshake, go to DONE with `data_o`=0 (loads) and `bus_err_o`=1;
  - any outstanding response is dropped (`rsp_ready_o`=0 afterwards).
- Undefined: no counter; REQ and RSP wait indefinitely.

## Structure
- Shared package `dm_bus_pkg`: FSM state enum `dm_bus_state_e`, default `TIMEOUT_CYCLES`, and the word-alignment mask constant.
- One sub-module, `dm_bus_watchdog`, holds the timeout counter with clear/enable/expired ports. It is instantiated only under `DM_BUS_TIMEOUT_EN`.

## Test plan
- Load word: addr 0x104, `rsp_rdata_i`=0xDEADBEEF, ready/valid immediate.
  - Expect `req_addr_o`=0x104, `req_wstrb_o`=0, `stall_o` high for 3 cycles.
  - Expect `data_o`=0xDEADBEEF in DONE.
- Store byte: addr 0x203, `dm_web_i`=4'b0111, `dm_sw_i`=0xAB000000.
  - Expect `req_addr_o`=0x200, `req_write_o`=1, `req_wstrb_o`=4'b1000, `req_wdata_o`=0xAB000000.
  - Expect `data_o` unchanged.
- Backpressure: `req_ready_i` low for 4 cycles, then `rsp_valid_i` delayed 3 cycles.
  - Expect `stall_o` high for 1+5+4=10 cycles and request fields stable throughout.
- `hold_i`=1 for 2 cycles at DONE.
  - Expect the FSM to stay in DONE, `stall_o`=0, and only one `req_valid_o` handshake.
- Error and reset: `rsp_err_i`=1 gives `bus_err_o`=1 for the DONE cycle only.
  - Pulling `rst` low in RSP gives IDLE and all outputs 0 within the same cycle.
- With `DM_BUS_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, `req_ready_i` held low.
  - Expect DONE after 8 REQ cycles with `bus_err_o`=1 and `data_o`=0.

Source files
------------

// File: rtl/dm_bus_pkg.sv
// Shared definitions for the data-memory bus master: FSM state encoding,
// default watchdog limit and the word-alignment mask.
`timescale 1ns/1ps
package dm_bus_pkg;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_REQ  = 2'd1,
    DM_RSP  = 2'd2,
    DM_DONE = 2'd3
  } dm_bus_state_e;

  // Default number of REQ+RSP cycles before an access is abandoned
  localparam int unsigned DM_BUS_TIMEOUT_CYCLES = 255;

  // Byte-offset bits cleared to form a word-aligned bus address
  localparam logic [1:0] DM_BUS_WORD_OFS_MASK = 2'b11;

endpackage

// File: rtl/dm_bus_master_if.sv
// Valid/ready data-bus channel between dm_bus_master and the memory side.
// Signal suffixes are relative to the master.
`timescale 1ns/1ps
interface dm_bus_master_if #(
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned WEB_BITS  = 4
) ();

  logic                 req_valid_o;
  logic                 req_ready_i;
  logic [ADDR_BITS-1:0] req_addr_o;
  logic                 req_write_o;
  logic [WEB_BITS-1:0]  req_wstrb_o;
  logic [DATA_BITS-1:0] req_wdata_o;
  logic                 rsp_valid_i;
  logic                 rsp_ready_o;
  logic [DATA_BITS-1:0] rsp_rdata_i;
  logic                 rsp_err_i;

  modport master (
    output req_valid_o, req_addr_o, req_write_o, req_wstrb_o, req_wdata_o,
    output rsp_ready_o,
    input  req_ready_i, rsp_valid_i, rsp_rdata_i, rsp_err_i
  );

  modport slave (
    input  req_valid_o, req_addr_o, req_write_o, req_wstrb_o, req_wdata_o,
    input  rsp_ready_o,
    output req_ready_i, rsp_valid_i, rsp_rdata_i, rsp_err_i
  );

endinterface

// File: rtl/dm_bus_watchdog.sv
// Access watchdog: counts enabled cycles since the last clear and flags
// expiry on the LIMIT-th enabled cycle.
`timescale 1ns/1ps
module dm_bus_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_BITS = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_BITS-1:0] count_q, count_d;

  // Expiry and next count; the count saturates once expired
  always_comb begin
    expired_o = en_i && (count_q == CNT_BITS'(LIMIT - 1));
    count_d   = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !expired_o) begin
      count_d = count_q + CNT_BITS'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dm_bus_master.sv
// Data-memory bus master: turns the MEM stage's combinational request into a
// valid/ready bus transaction and stalls the pipeline until it completes.
// Optional watchdog: define DM_BUS_TIMEOUT_EN to abandon stuck accesses.
`timescale 1ns/1ps
module dm_bus_master
  import dm_bus_pkg::*;
#(
  parameter int unsigned ADDR_BITS      = 32,
  parameter int unsigned DATA_BITS      = 32,
  parameter int unsigned WEB_BITS       = 4,
  parameter int unsigned TIMEOUT_CYCLES = DM_BUS_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] dm_addr_i,
  input  logic [DATA_BITS-1:0] dm_sw_i,
  input  logic [WEB_BITS-1:0]  dm_web_i,
  input  logic                 dm_rd_i,
  input  logic                 dm_wr_i,
  input  logic                 hold_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 stall_o,
  output logic                 bus_err_o,
  dm_bus_master_if.master      bus
);

  dm_bus_state_e        state_q, state_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 err_q, err_d;
  logic                 timeout;

`ifdef DM_BUS_TIMEOUT_EN
  // Counter is zero on the first REQ cycle because REQ is only entered from IDLE
  dm_bus_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst),
    .clr_i     (state_q == DM_IDLE),
    .en_i      ((state_q == DM_REQ) || (state_q == DM_RSP)),
    .expired_o (timeout)
  );
`else
  // No watchdog: the limit has no effect and the bus is waited on indefinitely
  assign timeout = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

  assign data_o = data_q;

  // Next-state, captured data/error and all bus/pipeline outputs
  always_comb begin
    state_d         = state_q;
    data_d          = data_q;
    err_d           = err_q;
    stall_o         = 1'b0;
    bus_err_o       = 1'b0;
    bus.req_valid_o = 1'b0;
    bus.req_addr_o  = '0;
    bus.req_write_o = 1'b0;
    bus.req_wstrb_o = '0;
    bus.req_wdata_o = '0;
    bus.rsp_ready_o = 1'b0;

    unique case (state_q)
      DM_IDLE: begin
        if (dm_rd_i || dm_wr_i) begin
          stall_o = 1'b1;
          state_d = DM_REQ;
        end
      end
      DM_REQ: begin
        stall_o         = 1'b1;
        bus.req_valid_o = 1'b1;
        bus.req_addr_o  = {dm_addr_i[ADDR_BITS-1:2],
                           dm_addr_i[1:0] & ~DM_BUS_WORD_OFS_MASK};
        bus.req_write_o = dm_wr_i;
        bus.req_wstrb_o = dm_wr_i ? ~dm_web_i : '0;
        bus.req_wdata_o = dm_sw_i;
        if (bus.req_ready_i) begin
          state_d = DM_RSP;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = DM_DONE;
          if (!dm_wr_i) data_d = '0;
        end
      end
      DM_RSP: begin
        stall_o         = 1'b1;
        bus.rsp_ready_o = 1'b1;
        if (bus.rsp_valid_i) begin
          err_d   = bus.rsp_err_i;
          state_d = DM_DONE;
          if (!dm_wr_i) data_d = bus.rsp_rdata_i;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = DM_DONE;
          if (!dm_wr_i) data_d = '0;
        end
      end
      DM_DONE: begin
        bus_err_o = err_q;
        if (!hold_i) state_d = DM_IDLE;
      end
      default: state_d = DM_IDLE;
    endcase
  end

  // State, read-data and error registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DM_IDLE;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      err_q   <= err_q & 1'b0 | err_d;
    end
  end

endmodule

// File: tb/tb_dm_bus_master.sv
// Directed self-checking bench for dm_bus_master. A negedge responder models
// the memory side with configurable request/response delays.
`timescale 1ns/1ps
module tb_dm_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_sw_i;
  logic [3:0]  dm_web_i;
  logic        dm_rd_i, dm_wr_i, hold_i;
  logic [31:0] data_o;
  logic        stall_o, bus_err_o;

  int checks = 0;
  int errors = 0;

  // Responder configuration
  bit tie_high  = 1'b0;
  int req_delay = 0;
  int rsp_delay = 0;
  int req_cnt   = 0;
  int rsp_cnt   = 0;

  always #5 clk = ~clk;

  dm_bus_master_if #(.ADDR_BITS(32), .DATA_BITS(32), .WEB_BITS(4)) bus ();

  dm_bus_master #(
    .ADDR_BITS      (32),
    .DATA_BITS      (32),
    .WEB_BITS       (4),
    .TIMEOUT_CYCLES (255)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dm_addr_i (dm_addr_i),
    .dm_sw_i   (dm_sw_i),
    .dm_web_i  (dm_web_i),
    .dm_rd_i   (dm_rd_i),
    .dm_wr_i   (dm_wr_i),
    .hold_i    (hold_i),
    .data_o    (data_o),
    .stall_o   (stall_o),
    .bus_err_o (bus_err_o),
    .bus       (bus)
  );

`ifdef DM_BUS_TIMEOUT_EN
  logic [31:0] data_t;
  logic        stall_t, bus_err_t;

  dm_bus_master_if #(.ADDR_BITS(32), .DATA_BITS(32), .WEB_BITS(4)) bus_t ();

  dm_bus_master #(
    .ADDR_BITS      (32),
    .DATA_BITS      (32),
    .WEB_BITS       (4),
    .TIMEOUT_CYCLES (8)
  ) dut_tmo (
    .clk       (clk),
    .rst       (rst),
    .dm_addr_i (dm_addr_i),
    .dm_sw_i   (dm_sw_i),
    .dm_web_i  (dm_web_i),
    .dm_rd_i   (dm_rd_i),
    .dm_wr_i   (dm_wr_i),
    .hold_i    (hold_i),
    .data_o    (data_t),
    .stall_o   (stall_t),
    .bus_err_o (bus_err_t),
    .bus       (bus_t)
  );

  initial begin
    bus_t.req_ready_i = 1'b0;
    bus_t.rsp_valid_i = 1'b0;
    bus_t.rsp_rdata_i = 32'hFFFF_FFFF;
    bus_t.rsp_err_i   = 1'b0;
  end
`endif

  // Memory-side responder, updated mid-cycle
  always @(negedge clk) begin
    if (tie_high) begin
      bus.req_ready_i = 1'b1;
      bus.rsp_valid_i = 1'b1;
    end else begin
      if (bus.req_valid_o) begin
        if (req_cnt >= req_delay) bus.req_ready_i = 1'b1;
        else begin bus.req_ready_i = 1'b0; req_cnt++; end
      end else begin
        bus.req_ready_i = 1'b0;
        req_cnt = 0;
      end
      if (bus.rsp_ready_o) begin
        if (rsp_cnt >= rsp_delay) bus.rsp_valid_i = 1'b1;
        else begin bus.rsp_valid_i = 1'b0; rsp_cnt++; end
      end else begin
        bus.rsp_valid_i = 1'b0;
        rsp_cnt = 0;
      end
    end
  end

  // Follows one access from its IDLE cycle to the negedge of its DONE cycle
  task automatic run_access(output int stalls, output int hs, output logic [31:0] a,
                            output logic w, output logic [3:0] s, output logic [31:0] wd,
                            output bit unstable, output bit err_early, output bit tmo);
    bit seen = 1'b0;
    bit prev_v = 1'b0;
    bit done = 1'b0;
    stalls = 0; hs = 0; a = '0; w = 1'b0; s = '0; wd = '0;
    unstable = 1'b0; err_early = 1'b0; tmo = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!stall_o) begin
        done = 1'b1;
      end else begin
        stalls++;
        if (bus_err_o) err_early = 1'b1;
        if (prev_v && !bus.req_valid_o) hs++;
        if (bus.req_valid_o) begin
          if (!seen) begin
            a = bus.req_addr_o; w = bus.req_write_o; s = bus.req_wstrb_o; wd = bus.req_wdata_o;
          end else if (a !== bus.req_addr_o || w !== bus.req_write_o ||
                       s !== bus.req_wstrb_o || wd !== bus.req_wdata_o) begin
            unstable = 1'b1;
          end
          seen = 1'b1;
        end
        prev_v = bus.req_valid_o;
      end
    end
    if (!done) tmo = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dm_addr_i = '0; dm_sw_i = '0; dm_web_i = 4'hF;
    dm_rd_i = 1'b0; dm_wr_i = 1'b0; hold_i = 1'b0;
    bus.rsp_rdata_i = '0; bus.rsp_err_i = 1'b0;
    bus.req_ready_i = 1'b0; bus.rsp_valid_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_o); end
    checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", data_o); end
    checks++; if (bus_err_o !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b want 0", bus_err_o); end
    checks++; if (bus.req_valid_o !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", bus.req_valid_o); end
    checks++; if (bus.rsp_ready_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_ready: got %b want 0", bus.rsp_ready_o); end
    checks++; if ({bus.req_addr_o, bus.req_wdata_o, bus.req_wstrb_o, bus.req_write_o} !== 69'h0) begin
      errors++; $display("FAIL reset_req_fields: got addr %h wdata %h wstrb %b write %b want all 0",
                         bus.req_addr_o, bus.req_wdata_o, bus.req_wstrb_o, bus.req_write_o);
    end
    #19 rst = 1'b1;
  endtask

  task automatic test_load();
    int st, hs; logic [31:0] a, wd; logic w; logic [3:0] s; bit un, ee, tmo;
    @(posedge clk); #1;
    tie_high = 1'b1;
    bus.rsp_rdata_i = 32'hDEAD_BEEF; bus.rsp_err_i = 1'b0;
    dm_addr_i = 32'h104; dm_sw_i = '0; dm_web_i = 4'hF; dm_rd_i = 1'b1;
    run_access(st, hs, a, w, s, wd, un, ee, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL load_timeout: access did not complete in 200 cycles"); end
    checks++; if (st !== 3) begin errors++; $display("FAIL load_stall_cycles: got %0d want 3", st); end
    checks++; if (a !== 32'h104) begin errors++; $display("FAIL load_addr: got %h want 00000104", a); end
    checks++; if ({w, s} !== 5'b0) begin errors++; $display("FAIL load_write_strb: got write %b wstrb %b want 0 0000", w, s); end
    checks++; if (data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_data: got %h want deadbeef", data_o); end
    checks++; if (hs !== 1) begin errors++; $display("FAIL load_handshakes: got %0d want 1", hs); end
    dm_rd_i = 1'b0;
    tie_high = 1'b0;
  endtask

  task automatic test_store();
    int st, hs; logic [31:0] a, wd; logic w; logic [3:0] s; bit un, ee, tmo;
    @(posedge clk); #1;
    req_delay = 0; rsp_delay = 0;
    bus.rsp_rdata_i = 32'h1234_5678;
    dm_addr_i = 32'h203; dm_web_i = 4'b0111; dm_sw_i = 32'hAB00_0000; dm_wr_i = 1'b1;
    run_access(st, hs, a, w, s, wd, un, ee, tmo);
    checks++; if (tmo || st !== 3) begin errors++; $display("FAIL store_stall_cycles: got %0d (timeout %b) want 3", st, tmo); end
    checks++; if (a !== 32'h200) begin errors++; $display("FAIL store_addr: got %h want 00000200", a); end
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL store_write: got %b want 1", w); end
    checks++; if (s !== 4'b1000) begin errors++; $display("FAIL store_wstrb: got %b want 1000", s); end
    checks++; if (wd !== 32'hAB00_0000) begin errors++; $display("FAIL store_wdata: got %h want ab000000", wd); end
    checks++; if (data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_data_kept: got %h want deadbeef", data_o); end
    dm_wr_i = 1'b0;
  endtask

  task automatic test_backpressure();
    int st, hs; logic [31:0] a, wd; logic w; logic [3:0] s; bit un, ee, tmo;
    @(posedge clk); #1;
    req_delay = 4; rsp_delay = 3;
    bus.rsp_rdata_i = 32'h0BAD_F00D;
    dm_addr_i = 32'h3FE; dm_web_i = 4'b0000; dm_sw_i = 32'h55AA_55AA; dm_rd_i = 1'b1;
    run_access(st, hs, a, w, s, wd, un, ee, tmo);
    checks++; if (tmo || st !== 10) begin errors++; $display("FAIL bp_stall_cycles: got %0d (timeout %b) want 10", st, tmo); end
    checks++; if (un !== 1'b0) begin errors++; $display("FAIL bp_fields_stable: got unstable %b want 0", un); end
    checks++; if (a !== 32'h3FC || s !== 4'b0000 || wd !== 32'h55AA_55AA) begin
      errors++; $display("FAIL bp_fields: got addr %h wstrb %b wdata %h want 000003fc 0000 55aa55aa", a, s, wd);
    end
    checks++; if (hs !== 1) begin errors++; $display("FAIL bp_handshakes: got %0d want 1", hs); end
    checks++; if (data_o !== 32'h0BAD_F00D) begin errors++; $display("FAIL bp_data: got %h want 0badf00d", data_o); end
    dm_rd_i = 1'b0;
    req_delay = 0; rsp_delay = 0;
  endtask

  task automatic test_back_to_back();
    int st, hs; logic [31:0] a, wd; logic w; logic [3:0] s; bit un, ee, tmo;
    @(posedge clk); #1;
    bus.rsp_rdata_i = 32'h1111_1111;
    dm_addr_i = 32'h10; dm_sw_i = '0; dm_web_i = 4'hF; dm_rd_i = 1'b1;
    run_access(st, hs, a, w, s, wd, un, ee, tmo);
    checks++; if (data_o !== 32'h1111_1111) begin errors++; $display("FAIL b2b_first_data: got %h want 11111111", data_o); end
    dm_addr_i = 32'h14;
    bus.rsp_rdata_i = 32'h2222_2222;
    run_access(st, hs, a, w, s, wd, un, ee, tmo);
    checks++; if (tmo || st !== 3) begin errors++; $display("FAIL b2b_second_stalls: got %0d (timeout %b) want 3", st, tmo); end
    checks++; if (a !== 32'h14) begin errors++; $display("FAIL b2b_second_addr: got %h want 00000014", a); end
    checks++; if (data_o !== 32'h2222_2222) begin errors++; $display("FAIL b2b_second_data: got %h want 22222222", data_o); end
    dm_rd_i = 1'b0;
  endtask

  task automatic test_hold();
    int st, hs; logic [31:0] a, wd; logic w; logic [3:0] s; bit un, ee, tmo;
    @(posedge clk); #1;
    bus.rsp_rdata_i = 32'hCAFE_0001;
    dm_addr_i = 32'h80; dm_rd_i = 1'b1;
    run_access(st, hs, a, w, s, wd, un, ee, tmo);
    hold_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (stall_o !== 1'b0 || bus.req_valid_o !== 1'b0) begin
        errors++; $display("FAIL hold_done_%0d: got stall %b req_valid %b want 0 0", i, stall_o, bus.req_valid_o);
      end
    end
    checks++; if (data_o !== 32'hCAFE_0001) begin errors++; $display("FAIL hold_data: got %h want cafe0001", data_o); end
    hold_i = 1'b0; dm_rd_i = 1'b0;
    @(negedge clk);
    checks++; if (stall_o !== 1'b0 || bus.req_valid_o !== 1'b0) begin
      errors++; $display("FAIL hold_release_idle: got stall %b req_valid %b want 0 0", stall_o, bus.req_valid_o);
    end
  endtask

  task automatic test_error();
    int st, hs; logic [31:0] a, wd; logic w; logic [3:0] s; bit un, ee, tmo;
    @(posedge clk); #1;
    bus.rsp_rdata_i = 32'h0000_0099; bus.rsp_err_i = 1'b1;
    dm_addr_i = 32'h40; dm_rd_i = 1'b1;
    run_access(st, hs, a, w, s, wd, un, ee, tmo);
    checks++; if (ee !== 1'b0) begin errors++; $display("FAIL err_before_done: got bus_err during stall %b want 0", ee); end
    checks++; if (bus_err_o !== 1'b1) begin errors++; $display("FAIL err_done: got %b want 1", bus_err_o); end
    checks++; if (data_o !== 32'h0000_0099) begin errors++; $display("FAIL err_data: got %h want 00000099", data_o); end
    dm_rd_i = 1'b0; bus.rsp_err_i = 1'b0;
    @(negedge clk);
    checks++; if (bus_err_o !== 1'b0) begin errors++; $display("FAIL err_after_done: got %b want 0", bus_err_o); end
  endtask

  task automatic test_long_wait();
    int st, hs; logic [31:0] a, wd; logic w; logic [3:0] s; bit un, ee, tmo;
    @(posedge clk); #1;
    req_delay = 30; rsp_delay = 0;
    bus.rsp_rdata_i = 32'h7777_0000;
    dm_addr_i = 32'h700; dm_rd_i = 1'b1;
    run_access(st, hs, a, w, s, wd, un, ee, tmo);
    checks++; if (tmo || st !== 33) begin errors++; $display("FAIL long_wait_stalls: got %0d (timeout %b) want 33", st, tmo); end
    checks++; if (data_o !== 32'h7777_0000 || bus_err_o !== 1'b0) begin
      errors++; $display("FAIL long_wait_result: got data %h err %b want 77770000 0", data_o, bus_err_o);
    end
    dm_rd_i = 1'b0;
    req_delay = 0;
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    @(posedge clk); #1;
    rsp_delay = 20;
    dm_addr_i = 32'h60; dm_rd_i = 1'b1;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.rsp_ready_o) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_mid_reach_rsp: got no rsp_ready within 10 cycles want 1"); end
    rst = 1'b0; dm_rd_i = 1'b0;
    #1;
    checks++; if (stall_o !== 1'b0 || bus.rsp_ready_o !== 1'b0 || bus.req_valid_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ctrl: got stall %b rsp_ready %b req_valid %b want 0 0 0",
                         stall_o, bus.rsp_ready_o, bus.req_valid_o);
    end
    checks++; if (data_o !== 32'h0 || bus_err_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_data: got data %h err %b want 0 0", data_o, bus_err_o);
    end
    checks++; if ({bus.req_addr_o, bus.req_wdata_o, bus.req_wstrb_o, bus.req_write_o} !== 69'h0) begin
      errors++; $display("FAIL rst_mid_req_fields: got addr %h wdata %h wstrb %b write %b want all 0",
                         bus.req_addr_o, bus.req_wdata_o, bus.req_wstrb_o, bus.req_write_o);
    end
    @(negedge clk);
    rst = 1'b1;
    rsp_delay = 0;
  endtask

`ifdef DM_BUS_TIMEOUT_EN
  task automatic test_timeout();
    int st = 0;
    bit done = 1'b0;
    @(posedge clk); #1;
    dm_addr_i = 32'h500; dm_rd_i = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (stall_t) st++;
      else done = 1'b1;
    end
    checks++; if (!done || st !== 9) begin errors++; $display("FAIL tmo_stall_cycles: got %0d (done %b) want 9", st, done); end
    checks++; if (bus_err_t !== 1'b1) begin errors++; $display("FAIL tmo_bus_err: got %b want 1", bus_err_t); end
    checks++; if (data_t !== 32'h0) begin errors++; $display("FAIL tmo_data: got %h want 0", data_t); end
    checks++; if (bus_t.rsp_ready_o !== 1'b0) begin errors++; $display("FAIL tmo_rsp_ready: got %b want 0", bus_t.rsp_ready_o); end
    dm_rd_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_store();
    test_backpressure();
    test_back_to_back();
    test_hold();
    test_error();
    test_long_wait();
    test_reset_mid();
`ifdef DM_BUS_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running want finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "time limit");
  end

endmodule
